ss_stack_ctrl_16b: RTL and testbench
====================================

// Module: ss_stack_ctrl_16b
// PURPOSE
//  Stack-side sequencer that consumes the stack pointer (SP) datapath: turns push/pop requests into
//  single-port stack-memory cycles while keeping SP (+1/-1/hold) in step. Sits between the control
//  unit (requester) and stack RAM; owns SP, full/empty flags and sticky over/underflow errors.
//  Empty-ascending stack: push writes mem[SP], then SP+1; pop reads mem[SP-1], then SP-1.
// PARAMETERS
//  BASE       16'h0000  SP value at reset / when empty (first stack word address)
//  DEPTH_LOG2 8         stack holds 2**DEPTH_LOG2 words; full when SP == BASE + 2**DEPTH_LOG2
// PORTS
//  CLK        in   1   single clock, all state updates on rising edge
//  reset      in   1   one clock; reset is synchronous and active-low
//  push_req   in   1   push request; held high until push_ack
//  push_data  in   16  word to push; sampled in accept cycle
//  pop_req    in   1   pop request; held high until pop_valid
//  err_clr    in   1   clears sticky ovf/unf (sync, 1 cycle)
//  ready      out  1   1 when FSM in IDLE (combinational from state)
//  push_ack   out  1   1-cycle pulse: push completed (or rejected, see ovf)
//  pop_valid  out  1   1-cycle pulse: pop_data valid
//  pop_data   out  16  popped word (registered)
//  sp         out  16  current stack pointer
//  full/empty out  1   SP == BASE+2**DEPTH_LOG2 / SP == BASE
//  ovf/unf    out  1   sticky: push while full / pop while empty
//  mem_addr   out  16  stack RAM address
//  mem_wdata  out  16  stack RAM write data
//  mem_we     out  1   stack RAM write strobe
//  mem_re     out  1   stack RAM read strobe
//  mem_rdata  in   16  stack RAM read data, valid 1 cycle after mem_re
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, sp=BASE, pop_data=0, ovf=unf=0; push_ack/pop_valid/mem_we/
//   mem_re=0. mem_we and mem_re are gated with reset so no RAM access in a reset cycle, even mid-op.
//  FSM IDLE->WRITE->IDLE (push); IDLE->READ->WAIT->RESP->IDLE (pop). Encoding 2-bit/3-bit in defs file.
//  Accept in IDLE at edge T: pop_req has priority; push_req accepted only if pop_req==0.
//   Refused push keeps waiting (no ack).
//  Push, normal: T+1 WRITE: mem_we=1, mem_addr=sp, mem_wdata=latched data, push_ack=1; sp<=sp+1 at
//   end of T+1. IDLE/ready in T+2.
//  Push while full: WRITE cycle with mem_we=0, push_ack=1, ovf<=1, sp unchanged.
//  Pop, normal: T+1 READ: mem_re=1, mem_addr=sp-1, sp<=sp-1 at end of T+1; T+2 WAIT:
//   pop_data<=mem_rdata; T+3 RESP: pop_valid=1; IDLE in T+4.
//  Pop while empty: mem_re=0, sp unchanged, unf<=1; pop_data<=16'h0000 and pop_valid in T+3 as normal.
//  SP arithmetic 16-bit modulo; full/empty guards ensure no wrap in legal use. mem_addr=0 when idle.
//  err_clr: clears ovf/unf; if a new error is set in the same cycle, set wins.
//  Requests dropped before ack: behaviour undefined for requester; FSM still completes the started op.
// STRUCTURE
//  ss_defs.vh: FSM state codes, SP_HOLD=2'd0 / SP_INC=2'd1 / SP_DEC=2'd2 select codes.
//  One sub-module: ss_sp_unit_16b (16-bit SP register + hold/+1/-1 select, sync active-low reset to
//   BASE); the FSM drives its select. Everything else inline.
// TESTING
//  1 Reset then idle: sp=BASE, empty=1, full=0, ready=1, no mem strobes for 10 cycles.
//  2 Push 16'hBEEF from BASE=0: mem_we @T+1 addr 0 data BEEF, push_ack @T+1, sp=1 @T+2; pop
//    -> mem_re addr 0 @T+1, pop_valid @T+3 with pop_data=BEEF, sp=0, empty=1.
//  3 DEPTH_LOG2=2: 4 pushes (1,2,3,4) -> full=1; 5th push -> ack, no mem_we, ovf=1;
//    4 pops return 4,3,2,1.
//  4 Pop on empty -> pop_valid with 0, unf=1, sp=BASE; err_clr -> unf=0 next cycle.
//  5 push_req and pop_req high together with sp=1 -> pop serviced first, push acked in next IDLE.
//  6 reset low in WRITE cycle -> mem_we=0 that cycle, sp=BASE, state IDLE next cycle.

Source files
------------

// File: rtl/ss_stack_ctrl_16b_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ss_stack_ctrl_16b_pkg
// Purpose  : Shared definitions for the stack sequencer: FSM state codes,
//            stack-pointer update select codes, data width and a helper that
//            derives the "full" stack-pointer value from BASE and DEPTH_LOG2.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ss_stack_ctrl_16b_pkg;

    localparam int DATA_W = 16;

    // Push path: IDLE -> WRITE -> IDLE
    // Pop path : IDLE -> READ -> WAIT -> RESP -> IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SP_HOLD = 2'd0,
        SP_INC  = 2'd1,
        SP_DEC  = 2'd2
    } sp_sel_e;

    // SP value at which the stack holds 2**depth_log2 words.
    function automatic logic [15:0] full_sp_of(input logic [15:0] base,
                                               input int          depth_log2);
        return base + 16'(32'd1 << depth_log2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ss_stack_ctrl_16b_if.sv
`default_nettype none
// ============================================================================
// Module   : ss_stack_ctrl_16b_if
// Purpose  : Bundles the requester-side handshake and the stack-RAM bus of
//            the stack sequencer.
// Ports    : slave modport (sequencer)
//              in : push_req, push_data, pop_req, err_clr, mem_rdata
//              out: ready, push_ack, pop_valid, pop_data, sp, full, empty,
//                   ovf, unf, mem_addr, mem_wdata, mem_we, mem_re
//            master modport (requester + RAM side) mirrors the directions.
// Revision : 1.0  initial release
// ============================================================================
interface ss_stack_ctrl_16b_if;

    logic        push_req;
    logic [15:0] push_data;
    logic        pop_req;
    logic        err_clr;
    logic        ready;
    logic        push_ack;
    logic        pop_valid;
    logic [15:0] pop_data;
    logic [15:0] sp;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;

    modport slave (
        input  push_req, push_data, pop_req, err_clr, mem_rdata,
        output ready, push_ack, pop_valid, pop_data, sp, full, empty,
               ovf, unf, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output push_req, push_data, pop_req, err_clr, mem_rdata,
        input  ready, push_ack, pop_valid, pop_data, sp, full, empty,
               ovf, unf, mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface
`default_nettype wire

// File: rtl/ss_sp_unit_16b.sv
`default_nettype none
// ============================================================================
// Module   : ss_sp_unit_16b
// Purpose  : 16-bit stack-pointer register with hold / +1 / -1 update.
//            Arithmetic is modulo 2**16; the controller's full/empty guards
//            keep legal use away from the wrap.
// Ports    : CLK    in  1   clock
//            reset  in  1   synchronous, active-low; loads BASE
//            sel    in  2   SP_HOLD / SP_INC / SP_DEC
//            sp     out 16  current stack pointer
// Revision : 1.0  initial release
// ============================================================================
module ss_sp_unit_16b
    import ss_stack_ctrl_16b_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  sp_sel_e     sel,
    output logic [15:0] sp
);

    logic [15:0] sp_q;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            sp_q <= BASE;
        end else begin
            case (sel)
                SP_INC:  sp_q <= sp_q + 16'd1;
                SP_DEC:  sp_q <= sp_q - 16'd1;
                default: sp_q <= sp_q;
            endcase
        end
    end

    assign sp = sp_q;

endmodule
`default_nettype wire

// File: rtl/ss_stack_ctrl_16b.sv
`default_nettype none
// ============================================================================
// Module   : ss_stack_ctrl_16b
// Purpose  : Stack-side sequencer. Turns push/pop requests into single-port
//            stack-RAM cycles and keeps the stack pointer in step
//            (empty-ascending: push writes mem[SP] then SP+1, pop reads
//            mem[SP-1] then SP-1). Owns full/empty and sticky ovf/unf.
// Ports    : CLK    in  1   clock, rising edge
//            reset  in  1   synchronous, active-low
//            bus    slave modport of ss_stack_ctrl_16b_if
//              requester: push_req/push_data/pop_req/err_clr in,
//                         ready/push_ack/pop_valid/pop_data out
//              status   : sp, full, empty, ovf, unf out
//              stack RAM: mem_addr/mem_wdata/mem_we/mem_re out,
//                         mem_rdata in (valid one cycle after mem_re)
// Revision : 1.0  initial release
// ============================================================================
module ss_stack_ctrl_16b
    import ss_stack_ctrl_16b_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'h0000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    ss_stack_ctrl_16b_if.slave   bus
);

    localparam logic [15:0] FULL_SP = full_sp_of(BASE, DEPTH_LOG2);

    state_e      state_q;
    state_e      state_d;
    sp_sel_e     sp_sel;
    logic [15:0] sp;
    logic        full;
    logic        empty;

    logic [15:0] push_data_q;
    logic [15:0] pop_data_q;
    logic        pop_empty_q;   // the pop in flight was issued on an empty stack
    logic        ovf_q;
    logic        unf_q;

    logic        latch_push;
    logic        set_ovf;
    logic        set_unf;
    logic        mem_we_c;
    logic        mem_re_c;
    logic        push_ack_c;
    logic        pop_valid_c;
    logic [15:0] mem_addr_c;

    ss_sp_unit_16b #(
        .BASE (BASE)
    ) u_sp_unit (
        .CLK   (CLK),
        .reset (reset),
        .sel   (sp_sel),
        .sp    (sp)
    );

    assign full  = (sp == FULL_SP);
    assign empty = (sp == BASE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and per-state strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sp_sel      = SP_HOLD;
        latch_push  = 1'b0;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        push_ack_c  = 1'b0;
        pop_valid_c = 1'b0;
        mem_addr_c  = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                // Pop wins a simultaneous request; the push keeps waiting.
                if (bus.pop_req) begin
                    state_d = ST_READ;
                end else if (bus.push_req) begin
                    state_d    = ST_WRITE;
                    latch_push = 1'b1;
                end
            end

            ST_WRITE: begin
                // A push on a full stack is still acknowledged so the
                // requester is released; only the RAM write and SP step
                // are suppressed.
                push_ack_c = 1'b1;
                state_d    = ST_IDLE;
                if (full) begin
                    set_ovf = 1'b1;
                end else begin
                    mem_we_c   = 1'b1;
                    mem_addr_c = sp;
                    sp_sel     = SP_INC;
                end
            end

            ST_READ: begin
                state_d = ST_WAIT;
                if (empty) begin
                    set_unf = 1'b1;
                end else begin
                    mem_re_c   = 1'b1;
                    mem_addr_c = sp - 16'd1;
                    sp_sel     = SP_DEC;
                end
            end

            ST_WAIT: begin
                state_d = ST_RESP;
            end

            ST_RESP: begin
                pop_valid_c = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!reset) begin
            push_data_q <= 16'h0000;
            pop_data_q  <= 16'h0000;
            pop_empty_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            if (latch_push) begin
                push_data_q <= bus.push_data;
            end

            if (state_q == ST_READ) begin
                pop_empty_q <= empty;
            end

            // RAM data arrives in WAIT; an underflowed pop returns zero.
            if (state_q == ST_WAIT) begin
                pop_data_q <= pop_empty_q ? 16'h0000 : bus.mem_rdata;
            end

            // A fresh error in the same cycle as err_clr stays set.
            if (set_ovf) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end

            if (set_unf) begin
                unf_q <= 1'b1;
            end else if (bus.err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes and pulses are gated with reset so an operation
    // caught mid-flight by reset never touches the RAM in that cycle.
    // ------------------------------------------------------------------
    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.push_ack  = push_ack_c  & reset;
    assign bus.pop_valid = pop_valid_c & reset;
    assign bus.mem_we    = mem_we_c    & reset;
    assign bus.mem_re    = mem_re_c    & reset;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = push_data_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.sp        = sp;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_ss_stack_ctrl_16b.sv
`default_nettype none
// ============================================================================
// Module   : tb_ss_stack_ctrl_16b
// Purpose  : Self-checking bench for ss_stack_ctrl_16b (BASE=0, DEPTH_LOG2=2).
//            Stimulus tasks queue the expected RAM/handshake events; a monitor
//            on the falling edge pops and compares each event the DUT shows.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_ss_stack_ctrl_16b;

    typedef enum logic [1:0] {EV_WR, EV_ACK, EV_RD, EV_POP} ev_kind_e;

    typedef struct {
        ev_kind_e    kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    logic CLK   = 1'b0;
    logic reset = 1'b0;

    ss_stack_ctrl_16b_if sif ();

    ss_stack_ctrl_16b #(
        .BASE       (16'h0000),
        .DEPTH_LOG2 (2)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 CLK = ~CLK;

    // Stack RAM model: synchronous write, read data one cycle after mem_re.
    logic [15:0] mem [0:255];
    always @(posedge CLK) begin
        if (sif.mem_we) mem[sif.mem_addr[7:0]] <= sif.mem_wdata;
        if (sif.mem_re) sif.mem_rdata <= mem[sif.mem_addr[7:0]];
    end

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic ev_t mk(ev_kind_e k, logic [15:0] a, logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic see_event(input ev_kind_e k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s: got addr %h data %h, required no event", k.name(), a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.addr !== a || e.data !== d) begin
                fails++;
                $display("FAIL event: got %s addr %h data %h, required %s addr %h data %h",
                         k.name(), a, d, e.kind.name(), e.addr, e.data);
            end
        end
    endtask

    // Monitor: compares every event the DUT presents against the scoreboard.
    always @(negedge CLK) begin
        if (sif.mem_we)    see_event(EV_WR,  sif.mem_addr, sif.mem_wdata);
        if (sif.push_ack)  see_event(EV_ACK, 16'h0000, 16'h0000);
        if (sif.mem_re)    see_event(EV_RD,  sif.mem_addr, 16'h0000);
        if (sif.pop_valid) see_event(EV_POP, 16'h0000, sif.pop_data);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_push(input logic [15:0] d, input logic [15:0] addr, input bit reject);
        int lat;
        lat = 0;
        if (!reject) exp_q.push_back(mk(EV_WR, addr, d));
        exp_q.push_back(mk(EV_ACK, 16'h0000, 16'h0000));
        sif.push_req  = 1'b1;
        sif.push_data = d;
        for (int i = 0; i < 20; i++) begin
            step();
            lat = i + 1;
            if (sif.push_ack) break;
        end
        check("push_ack_latency", 16'(lat), 16'd1);
        sif.push_req = 1'b0;
        step();
    endtask

    task automatic do_pop(input logic [15:0] addr, input logic [15:0] d, input bit on_empty);
        int lat;
        lat = 0;
        if (!on_empty) exp_q.push_back(mk(EV_RD, addr, 16'h0000));
        exp_q.push_back(mk(EV_POP, 16'h0000, d));
        sif.pop_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            lat = i + 1;
            if (sif.pop_valid) break;
        end
        check("pop_valid_latency", 16'(lat), 16'd3);
        sif.pop_req = 1'b0;
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic strobe_seen;
        int   lat;

        sif.push_req  = 1'b0;
        sif.push_data = 16'h0000;
        sif.pop_req   = 1'b0;
        sif.err_clr   = 1'b0;

        // 1: reset, then idle with no RAM strobes
        repeat (3) step();
        check("rst_sp", sif.sp, 16'h0000);
        check("rst_pop_data", sif.pop_data, 16'h0000);
        reset = 1'b1;
        check("idle_empty", 16'(sif.empty), 16'd1);
        check("idle_full", 16'(sif.full), 16'd0);
        check("idle_ready", 16'(sif.ready), 16'd1);
        check("idle_ovf_unf", {14'd0, sif.ovf, sif.unf}, 16'd0);
        strobe_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            strobe_seen = strobe_seen | sif.mem_we | sif.mem_re;
        end
        check("idle_strobes", 16'(strobe_seen), 16'd0);

        // 2: single push / pop round trip
        do_push(16'hBEEF, 16'h0000, 1'b0);
        check("t2_sp_after_push", sif.sp, 16'h0001);
        do_pop(16'h0000, 16'hBEEF, 1'b0);
        check("t2_sp_after_pop", sif.sp, 16'h0000);
        check("t2_empty", 16'(sif.empty), 16'd1);

        // 3: fill a 4-deep stack, overflow, drain in LIFO order
        do_push(16'h0001, 16'h0000, 1'b0);
        do_push(16'h0002, 16'h0001, 1'b0);
        do_push(16'h0003, 16'h0002, 1'b0);
        do_push(16'h0004, 16'h0003, 1'b0);
        check("t3_full", 16'(sif.full), 16'd1);
        check("t3_sp_full", sif.sp, 16'h0004);
        do_push(16'h0005, 16'h0004, 1'b1);
        check("t3_ovf", 16'(sif.ovf), 16'd1);
        check("t3_sp_after_ovf", sif.sp, 16'h0004);
        do_pop(16'h0003, 16'h0004, 1'b0);
        do_pop(16'h0002, 16'h0003, 1'b0);
        do_pop(16'h0001, 16'h0002, 1'b0);
        do_pop(16'h0000, 16'h0001, 1'b0);
        check("t3_empty", 16'(sif.empty), 16'd1);

        // 4: underflow returns zero, err_clr clears both sticky flags
        do_pop(16'h0000, 16'h0000, 1'b1);
        check("t4_unf", 16'(sif.unf), 16'd1);
        check("t4_sp", sif.sp, 16'h0000);
        sif.err_clr = 1'b1;
        step();
        sif.err_clr = 1'b0;
        check("t4_unf_cleared", 16'(sif.unf), 16'd0);
        check("t4_ovf_cleared", 16'(sif.ovf), 16'd0);

        // 5: simultaneous push and pop at sp=1 -> pop first, push next
        do_push(16'h1111, 16'h0000, 1'b0);
        exp_q.push_back(mk(EV_RD,  16'h0000, 16'h0000));
        exp_q.push_back(mk(EV_POP, 16'h0000, 16'h1111));
        exp_q.push_back(mk(EV_WR,  16'h0000, 16'h2222));
        exp_q.push_back(mk(EV_ACK, 16'h0000, 16'h0000));
        sif.push_req  = 1'b1;
        sif.push_data = 16'h2222;
        sif.pop_req   = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat = i + 1;
            if (sif.pop_valid) break;
        end
        check("t5_pop_first_latency", 16'(lat), 16'd3);
        sif.pop_req = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat = i + 1;
            if (sif.push_ack) break;
        end
        check("t5_push_after_latency", 16'(lat), 16'd2);
        sif.push_req = 1'b0;
        step();
        check("t5_sp", sif.sp, 16'h0001);
        do_pop(16'h0000, 16'h2222, 1'b0);

        // 6: reset asserted during a WRITE cycle
        do_push(16'h7777, 16'h0000, 1'b0);
        sif.push_req  = 1'b1;
        sif.push_data = 16'hABCD;
        step();
        check("t6_in_write", 16'(sif.ready), 16'd0);
        reset = 1'b0;
        #1;
        check("t6_we_gated", 16'(sif.mem_we), 16'd0);
        check("t6_ack_gated", 16'(sif.push_ack), 16'd0);
        sif.push_req = 1'b0;
        step();
        reset = 1'b1;
        check("t6_sp_base", sif.sp, 16'h0000);
        check("t6_ready", 16'(sif.ready), 16'd1);

        repeat (3) step();
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
